// File: rtl/entropy_health_pkg.sv
// Shared types, cause bit positions and counter-width helpers for the entropy health monitor.
package entropy_health_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } ch_state_e;

  localparam int unsigned CAUSE_RCT = 0;
  localparam int unsigned CAUSE_APT = 1;
  localparam int unsigned CAUSE_W   = 2;

  // Width of a counter that must hold values 0..limit inclusive.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/entropy_health_monitor_if.sv
// Sample/alarm bus between the QRNG sources, the health monitor and the Guard logic.
interface entropy_health_monitor_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 64
);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        alarm_clear;
  logic [NUM_CH-1:0]        alarm;
  logic                     alarm_any;
  logic [2*NUM_CH-1:0]      fail_cause;
  logic [NUM_CH-1:0]        ch_ok;

  modport master (
    output in_valid, in_data, alarm_clear,
    input  alarm, alarm_any, fail_cause, ch_ok
  );

  modport slave (
    input  in_valid, in_data, alarm_clear,
    output alarm, alarm_any, fail_cause, ch_ok
  );

endinterface

// File: rtl/entropy_health_channel.sv
// One entropy channel: IDLE/RUN/FAIL FSM with repetition-count and adaptive-proportion tests.
// Optional start-up gating of ch_ok is enabled by defining ENTROPY_HEALTH_STARTUP_EN.
module entropy_health_channel
  import entropy_health_pkg::*;
#(
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned RCT_CUTOFF      = 32,
  parameter int unsigned APT_WINDOW      = 512,
  parameter int unsigned APT_CUTOFF      = 64,
  parameter int unsigned STARTUP_SAMPLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              alarm_clear,
  output logic              alarm,
  output logic [CAUSE_W-1:0] fail_cause,
  output logic              ch_ok
);

  localparam int unsigned RCT_W     = cnt_w(RCT_CUTOFF);
  localparam int unsigned APT_CNT_W = cnt_w(APT_CUTOFF);
  localparam int unsigned APT_IDX_W = cnt_w(APT_WINDOW);

  // Elaboration-time guard on the configuration limits.
  if (RCT_CUTOFF < 2 || APT_WINDOW < 2 || APT_CUTOFF < 2 || APT_CUTOFF > APT_WINDOW ||
      STARTUP_SAMPLES < 1) begin : g_bad_cfg
    $error("entropy_health_channel: illegal cutoff/window configuration");
  end

  ch_state_e            state_q, state_nxt;
  logic [DATA_W-1:0]    last_q, apt_ref_q;
  logic [RCT_W-1:0]     rct_cnt_q, rct_nxt;
  logic [APT_IDX_W-1:0] apt_idx_q, apt_idx_nxt;
  logic [APT_CNT_W-1:0] apt_cnt_q, apt_cnt_nxt;
  logic [CAUSE_W-1:0]   cause_q;
  logic                 apt_roll, rct_fail, apt_fail, any_fail;

  // Candidate counter updates and test verdicts for the sample on in_data.
  always_comb begin
    rct_nxt     = (in_data == last_q) ? rct_cnt_q + RCT_W'(1) : RCT_W'(1);
    apt_roll    = (apt_idx_q == APT_IDX_W'(APT_WINDOW));
    apt_idx_nxt = apt_roll ? APT_IDX_W'(1) : apt_idx_q + APT_IDX_W'(1);
    apt_cnt_nxt = apt_cnt_q;
    if (apt_roll) begin
      apt_cnt_nxt = APT_CNT_W'(1);
    end else if (in_data == apt_ref_q) begin
      apt_cnt_nxt = apt_cnt_q + APT_CNT_W'(1);
    end
    rct_fail = (rct_nxt >= RCT_W'(RCT_CUTOFF));
    apt_fail = !apt_roll && (apt_cnt_nxt >= APT_CNT_W'(APT_CUTOFF));
    any_fail = rct_fail || apt_fail;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: clear dominates, otherwise only a valid sample can move the channel.
  always_comb begin
    state_nxt = state_q;
    if (alarm_clear) begin
      state_nxt = IDLE;
    end else if (in_valid) begin
      case (state_q)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = any_fail ? FAIL : RUN;
        default: state_nxt = state_q;
      endcase
    end
  end

  // Test counters and sticky cause; frozen outside IDLE/RUN sample consumption.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q    <= '0;
      apt_ref_q <= '0;
      rct_cnt_q <= '0;
      apt_idx_q <= '0;
      apt_cnt_q <= '0;
      cause_q   <= '0;
    end else if (alarm_clear) begin
      last_q    <= '0;
      apt_ref_q <= '0;
      rct_cnt_q <= '0;
      apt_idx_q <= '0;
      apt_cnt_q <= '0;
      cause_q   <= '0;
    end else if (in_valid) begin
      case (state_q)
        IDLE: begin
          last_q    <= in_data;
          apt_ref_q <= in_data;
          rct_cnt_q <= RCT_W'(1);
          apt_idx_q <= APT_IDX_W'(1);
          apt_cnt_q <= APT_CNT_W'(1);
        end
        RUN: begin
          last_q             <= in_data;
          rct_cnt_q          <= rct_nxt;
          apt_idx_q          <= apt_idx_nxt;
          apt_cnt_q          <= apt_cnt_nxt;
          cause_q[CAUSE_RCT] <= rct_fail;
          cause_q[CAUSE_APT] <= apt_fail;
          if (apt_roll) begin
            apt_ref_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENTROPY_HEALTH_STARTUP_EN
  localparam int unsigned SU_W = cnt_w(STARTUP_SAMPLES);

  logic [SU_W-1:0] su_cnt_q;
  logic            su_done;

  assign su_done = (su_cnt_q == SU_W'(STARTUP_SAMPLES));

  // Start-up counter: passing samples consumed in RUN, saturating at the threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      su_cnt_q <= '0;
    end else if (alarm_clear) begin
      su_cnt_q <= '0;
    end else if (in_valid && state_q == RUN && !any_fail && !su_done) begin
      su_cnt_q <= su_cnt_q + SU_W'(1);
    end
  end
`else
  logic su_done;

  assign su_done = 1'b1;
`endif

  // Outputs decoded from registered state only.
  always_comb begin
    alarm      = (state_q == FAIL);
    fail_cause = cause_q;
    ch_ok      = (state_q == RUN) && su_done;
  end

endmodule

// File: rtl/entropy_health_monitor.sv
// Multi-channel continuous health monitor for QRNG entropy sources (RCT + APT per channel).
// Optional feature macro: ENTROPY_HEALTH_STARTUP_EN gates ch_ok behind a start-up sample count.
module entropy_health_monitor
  import entropy_health_pkg::*;
#(
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned RCT_CUTOFF      = 32,
  parameter int unsigned APT_WINDOW      = 512,
  parameter int unsigned APT_CUTOFF      = 64,
  parameter int unsigned STARTUP_SAMPLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  entropy_health_monitor_if.slave  bus
);

  logic [NUM_CH-1:0]         alarm_w;
  logic [NUM_CH-1:0]         ok_w;
  logic [CAUSE_W*NUM_CH-1:0] cause_w;

  // Independent per-channel monitors.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    entropy_health_channel #(
      .DATA_W          (DATA_W),
      .RCT_CUTOFF      (RCT_CUTOFF),
      .APT_WINDOW      (APT_WINDOW),
      .APT_CUTOFF      (APT_CUTOFF),
      .STARTUP_SAMPLES (STARTUP_SAMPLES)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (bus.in_valid[c]),
      .in_data     (bus.in_data[c*DATA_W +: DATA_W]),
      .alarm_clear (bus.alarm_clear[c]),
      .alarm       (alarm_w[c]),
      .fail_cause  (cause_w[c*CAUSE_W +: CAUSE_W]),
      .ch_ok       (ok_w[c])
    );
  end

  assign bus.alarm      = alarm_w;
  assign bus.alarm_any  = |alarm_w;
  assign bus.fail_cause = cause_w;
  assign bus.ch_ok      = ok_w;

endmodule

// File: tb/tb_entropy_health_monitor.sv
// Directed self-checking bench for entropy_health_monitor (2 channels, small cutoffs).
module tb_entropy_health_monitor;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DATA_W = 64;
`ifdef ENTROPY_HEALTH_STARTUP_EN
  localparam logic OK_RUN = 1'b0;
`else
  localparam logic OK_RUN = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  entropy_health_monitor_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  entropy_health_monitor #(
    .DATA_W          (DATA_W),
    .NUM_CH          (NUM_CH),
    .RCT_CUTOFF      (8),
    .APT_WINDOW      (16),
    .APT_CUTOFF      (6),
    .STARTUP_SAMPLES (20)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are stable for checking on return.
  task automatic step(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                      input logic [1:0] clr);
    bus.in_valid    = v;
    bus.in_data     = {d1, d0};
    bus.alarm_clear = clr;
    @(posedge clk);
    #1;
    bus.in_valid    = '0;
    bus.alarm_clear = '0;
  endtask

  task automatic send0(input logic [63:0] d);
    step(2'b01, d, 64'h0, 2'b00);
  endtask

  task automatic clear0();
    step(2'b00, 64'h0, 64'h0, 2'b01);
  endtask

  logic [63:0] seq2 [11];
  logic [63:0] seq3 [28];

  initial begin
    seq2 = '{64'h1, 64'h2, 64'h1, 64'h3, 64'h1, 64'h4, 64'h1, 64'h5, 64'h1, 64'h6, 64'h1};
    seq3 = '{64'h1, 64'h2, 64'h1, 64'h3, 64'h1, 64'h4, 64'h1, 64'h5, 64'h1, 64'h6,
             64'h7, 64'h8, 64'h9, 64'hA, 64'hB, 64'hC,
             64'h1, 64'h2, 64'h1, 64'h3, 64'h1, 64'h4, 64'h1, 64'h5, 64'h6, 64'h1,
             64'h7, 64'h1};

    reset_n         = 1'b0;
    bus.in_valid    = '0;
    bus.in_data     = '0;
    bus.alarm_clear = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("reset_alarm", 64'(bus.alarm), 64'h0);
    expect_eq("reset_alarm_any", 64'(bus.alarm_any), 64'h0);
    expect_eq("reset_cause", 64'(bus.fail_cause), 64'h0);
    expect_eq("reset_ch_ok", 64'(bus.ch_ok), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // RCT: run of identical samples straddling the APT window boundary.
    for (int i = 0; i < 12; i++) begin
      send0(64'h100 + 64'(i));
      if (i == 0) expect_eq("rct_first_ch_ok", 64'(bus.ch_ok[0]), 64'(OK_RUN));
    end
    for (int i = 0; i < 8; i++) begin
      send0(64'hA5A5_A5A5_A5A5_A5A5);
      if (i == 6) expect_eq("rct_7_no_alarm", 64'(bus.alarm), 64'h0);
    end
    expect_eq("rct_8_alarm", 64'(bus.alarm), 64'h1);
    expect_eq("rct_8_cause", 64'(bus.fail_cause), 64'h1);
    expect_eq("rct_alarm_any", 64'(bus.alarm_any), 64'h1);
    expect_eq("rct_fail_ch_ok", 64'(bus.ch_ok), 64'h0);
    send0(64'h1234);
    expect_eq("fail_hold_cause", 64'(bus.fail_cause), 64'h1);
    expect_eq("fail_hold_alarm", 64'(bus.alarm), 64'h1);

    // Clear with simultaneous valid: sample must be dropped.
    step(2'b01, 64'h7, 64'h0, 2'b01);
    expect_eq("clr_alarm", 64'(bus.alarm), 64'h0);
    expect_eq("clr_cause", 64'(bus.fail_cause), 64'h0);
    expect_eq("clr_ch_ok", 64'(bus.ch_ok), 64'h0);
    step(2'b00, 64'h0, 64'h0, 2'b00);
    expect_eq("idle_ch_ok", 64'(bus.ch_ok), 64'h0);
    for (int i = 0; i < 6; i++) begin
      send0(64'h7);
      if (i == 0) expect_eq("rerun_ch_ok", 64'(bus.ch_ok[0]), 64'(OK_RUN));
      if (i == 4) expect_eq("apt_5_dropped_no_alarm", 64'(bus.alarm), 64'h0);
    end
    expect_eq("apt_6_alarm", 64'(bus.alarm), 64'h1);
    expect_eq("apt_6_cause", 64'(bus.fail_cause), 64'h2);
    clear0();

    // APT with interleaved matches of the window reference.
    for (int i = 0; i < 11; i++) begin
      send0(seq2[i]);
      if (i == 9) expect_eq("apt_seq_10_no_alarm", 64'(bus.alarm), 64'h0);
    end
    expect_eq("apt_seq_alarm", 64'(bus.alarm), 64'h1);
    expect_eq("apt_seq_cause", 64'(bus.fail_cause), 64'h2);
    clear0();

    // APT window rollover restarts the match count.
    for (int i = 0; i < 28; i++) begin
      send0(seq3[i]);
      if (i == 15) expect_eq("win_end_no_alarm", 64'(bus.alarm), 64'h0);
      if (i == 16) expect_eq("win_new_no_alarm", 64'(bus.alarm), 64'h0);
      if (i == 25) expect_eq("win_5_no_alarm", 64'(bus.alarm), 64'h0);
    end
    expect_eq("win_6_alarm", 64'(bus.alarm), 64'h1);
    expect_eq("win_6_cause", 64'(bus.fail_cause), 64'h2);
    clear0();

    // Asynchronous reset mid-sequence.
    for (int i = 0; i < 6; i++) step(2'b10, 64'h0, 64'hB, 2'b00);
    expect_eq("ch1_alarm", 64'(bus.alarm), 64'h2);
    expect_eq("ch1_cause", 64'(bus.fail_cause), 64'h8);
    for (int i = 0; i < 5; i++) send0(64'h9);
    expect_eq("pre_reset_ch_ok", 64'(bus.ch_ok[0]), 64'(OK_RUN));
    #2;
    reset_n = 1'b0;
    #1;
    expect_eq("async_alarm", 64'(bus.alarm), 64'h0);
    expect_eq("async_alarm_any", 64'(bus.alarm_any), 64'h0);
    expect_eq("async_cause", 64'(bus.fail_cause), 64'h0);
    expect_eq("async_ch_ok", 64'(bus.ch_ok), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) send0(64'h9);
    expect_eq("post_reset_no_alarm", 64'(bus.alarm), 64'h0);
    expect_eq("post_reset_ch_ok", 64'(bus.ch_ok[0]), 64'(OK_RUN));

`ifdef ENTROPY_HEALTH_STARTUP_EN
    // Start-up: ch_ok after 20 passing RUN samples (21 samples including the IDLE one).
    clear0();
    for (int i = 0; i < 21; i++) begin
      send0(64'd100 + 64'(i));
      if (i == 19) expect_eq("su_19_ch_ok", 64'(bus.ch_ok[0]), 64'h0);
    end
    expect_eq("su_20_ch_ok", 64'(bus.ch_ok[0]), 64'h1);
    clear0();
    expect_eq("su_clr_ch_ok", 64'(bus.ch_ok[0]), 64'h0);
    for (int i = 0; i < 30; i++) begin
      send0((i >= 9 && i <= 16) ? 64'hDEAD : 64'd200 + 64'(i));
      if (i == 16) expect_eq("su_fault_alarm", 64'(bus.alarm[0]), 64'h1);
      if (i == 16) expect_eq("su_fault_cause", 64'(bus.fail_cause[1:0]), 64'h1);
    end
    expect_eq("su_fault_ch_ok", 64'(bus.ch_ok[0]), 64'h0);
    expect_eq("su_fault_alarm_end", 64'(bus.alarm[0]), 64'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
